// File: rtl/tmss_unlock_pkg.sv
// Shared definitions for the TMSS unlock bus master: FSM states, cycle table, timeout.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package tmss_unlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_REL,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [22:0] ADDR_VERSION = 23'h508000;
  localparam logic [22:0] ADDR_SIG0    = 23'h50A000;
  localparam logic [22:0] ADDR_SIG1    = 23'h50A001;
  localparam logic [22:0] ADDR_BANK    = 23'h50A080;

  localparam logic [15:0] SIG_SE = 16'h5345;
  localparam logic [15:0] SIG_GA = 16'h4741;

  // One bus cycle: address, direction, write word and active-low data strobes.
  typedef struct packed {
    logic [22:0] addr;
    logic        rw;
    logic [15:0] wdat;
    logic        uds_n;
    logic        lds_n;
  } cyc_t;

  // Cycle table indexed by position in the unlock sequence.
  function automatic cyc_t cyc_desc(input logic [1:0] idx, input logic bank_val);
    cyc_t c;
    c.addr  = ADDR_VERSION;
    c.rw    = 1'b1;
    c.wdat  = 16'h0000;
    c.uds_n = 1'b0;
    c.lds_n = 1'b0;
    case (idx)
      2'd1: begin c.addr = ADDR_SIG0; c.rw = 1'b0; c.wdat = SIG_SE; end
      2'd2: begin c.addr = ADDR_SIG1; c.rw = 1'b0; c.wdat = SIG_GA; end
      2'd3: begin
        c.addr  = ADDR_BANK;
        c.rw    = 1'b0;
        c.wdat  = {15'h0000, bank_val};
        c.uds_n = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmss_bus_cycle.sv
// Bus-cycle engine: runs ADDR/STRB/REL per cycle, chains cycles, ends in DONE or ERR.
// Latency: 3 clocks minimum per cycle (ADDR, STRB with immediate DTACK, REL).
// Backpressure: STRB holds while DTACK=1; aborts to ERR after TIMEOUT strobe clocks.
module tmss_bus_cycle
  import tmss_unlock_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        MCLK,
  input  logic        SRES_N,
  input  logic        go,
  input  logic        more,
  input  cyc_t        cyc,
  input  logic        DTACK,
  output state_t      state,
  output logic [22:0] VA,
  output logic [15:0] VD_o,
  output logic        data_out_en,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] tcnt;
  logic          uds_q;
  logic          lds_q;
  logic          load;

  // A new cycle is loaded from idle on go, or straight from REL when more cycles follow.
  assign load = (state == ST_IDLE && go) || (state == ST_REL && more);

  // Handshake FSM with registered bus outputs; reset releases every strobe at once.
  always_ff @(posedge MCLK or negedge SRES_N) begin
    if (!SRES_N) begin
      state       <= ST_IDLE;
      VA          <= '0;
      VD_o        <= '0;
      data_out_en <= 1'b0;
      AS          <= 1'b1;
      UDS         <= 1'b1;
      LDS         <= 1'b1;
      RW          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      tcnt        <= '0;
      uds_q       <= 1'b1;
      lds_q       <= 1'b1;
    end else if (load) begin
      state       <= ST_ADDR;
      VA          <= cyc.addr;
      RW          <= cyc.rw;
      VD_o        <= cyc.rw ? 16'h0000 : cyc.wdat;
      data_out_en <= ~cyc.rw;
      uds_q       <= cyc.uds_n;
      lds_q       <= cyc.lds_n;
      busy        <= 1'b1;
    end else begin
      case (state)
        ST_ADDR: begin
          state <= ST_STRB;
          AS    <= 1'b0;
          UDS   <= uds_q;
          LDS   <= lds_q;
          tcnt  <= '0;
        end
        ST_STRB: begin
          if (!DTACK) begin
            state <= ST_REL;
            AS    <= 1'b1;
            UDS   <= 1'b1;
            LDS   <= 1'b1;
          end else if (tcnt == TLAST) begin
            state       <= ST_ERR;
            AS          <= 1'b1;
            UDS         <= 1'b1;
            LDS         <= 1'b1;
            RW          <= 1'b1;
            VD_o        <= '0;
            data_out_en <= 1'b0;
            error       <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        ST_REL: begin
          state       <= ST_DONE;
          RW          <= 1'b1;
          VD_o        <= '0;
          data_out_en <= 1'b0;
          done        <= 1'b1;
        end
        ST_DONE, ST_ERR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          error <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tmss_unlock_master.sv
// TMSS unlock initiator: reads version, writes "SE","GA", optional bank write.
// Latency: 3 clocks per bus cycle minimum, plus 1 DONE/ERR clock; start->ADDR 1 clock.
// Backpressure: waits on DTACK per cycle; start is ignored unless idle.
module tmss_unlock_master
  import tmss_unlock_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        MCLK,
  input  logic        SRES_N,
  input  logic        start,
  input  logic        bank_en,
  input  logic        bank_val,
  input  logic        DTACK,
  input  logic [15:0] VD_i,
  output logic [22:0] VA,
  output logic [15:0] VD_o,
  output logic        data_out_en,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic        busy,
  output logic        done,
  output logic        skipped,
  output logic        error,
  output logic [3:0]  version
);

  state_t      state;
  logic [1:0]  cyc_idx;
  logic [1:0]  nxt_idx;
  logic        bank_en_q;
  logic        bank_val_q;
  logic        idle;
  logic        more;
  cyc_t        cyc;
  logic [11:0] vd_unused;

  assign vd_unused = VD_i[15:4];
  assign idle      = (state == ST_IDLE);
  // Descriptor for the cycle about to be loaded: C0 from idle, else the successor.
  assign nxt_idx   = idle ? 2'd0 : cyc_idx + 2'd1;
  assign cyc       = cyc_desc(nxt_idx, bank_val_q);

  // Whether another cycle follows the one now in REL; a zero version ends the run.
  always_comb begin
    more = 1'b0;
    case (cyc_idx)
      2'd0:    more = (version != 4'd0);
      2'd1:    more = 1'b1;
      2'd2:    more = bank_en_q;
      default: more = 1'b0;
    endcase
  end

  // Sequence bookkeeping: latch options at start, capture version, advance index.
  always_ff @(posedge MCLK or negedge SRES_N) begin
    if (!SRES_N) begin
      cyc_idx    <= 2'd0;
      bank_en_q  <= 1'b0;
      bank_val_q <= 1'b0;
      skipped    <= 1'b0;
      version    <= 4'd0;
    end else begin
      if (idle && start) begin
        cyc_idx    <= 2'd0;
        bank_en_q  <= bank_en;
        bank_val_q <= bank_val;
        skipped    <= 1'b0;
        version    <= 4'd0;
      end
      if (state == ST_STRB && !DTACK && cyc_idx == 2'd0) begin
        version <= VD_i[3:0];
      end
      if (state == ST_REL) begin
        if (more) begin
          cyc_idx <= nxt_idx;
        end else if (cyc_idx == 2'd0) begin
          skipped <= 1'b1;
        end
      end
    end
  end

  tmss_bus_cycle #(.TIMEOUT(TIMEOUT)) u_cycle (
    .MCLK        (MCLK),
    .SRES_N      (SRES_N),
    .go          (start),
    .more        (more),
    .cyc         (cyc),
    .DTACK       (DTACK),
    .state       (state),
    .VA          (VA),
    .VD_o        (VD_o),
    .data_out_en (data_out_en),
    .AS          (AS),
    .UDS         (UDS),
    .LDS         (LDS),
    .RW          (RW),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

endmodule

// File: tb/tb_tmss_unlock_master.sv
// Directed bench for tmss_unlock_master with a bus responder and access monitor.
// Latency: n/a.
// Backpressure: responder acks on the 2nd strobe clock, or never in timeout mode.
module tb_tmss_unlock_master;

  logic        MCLK = 1'b0;
  logic        SRES_N = 1'b0;
  logic        start = 1'b0;
  logic        bank_en = 1'b0;
  logic        bank_val = 1'b0;
  logic        DTACK = 1'b1;
  logic [15:0] VD_i = 16'h0000;
  logic [22:0] VA;
  logic [15:0] VD_o;
  logic        data_out_en, AS, UDS, LDS, RW;
  logic        busy, done, skipped, error;
  logic [3:0]  version;

  int checks = 0;
  int failures = 0;

  tmss_unlock_master dut (
    .MCLK(MCLK), .SRES_N(SRES_N), .start(start), .bank_en(bank_en), .bank_val(bank_val),
    .DTACK(DTACK), .VD_i(VD_i), .VA(VA), .VD_o(VD_o), .data_out_en(data_out_en),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .busy(busy), .done(done),
    .skipped(skipped), .error(error), .version(version)
  );

  always #5 MCLK = ~MCLK;

  // Responder and monitor state
  int          ack_mode = 1;
  logic [15:0] rdata = 16'h0000;
  int          strb_cnt = 0;
  int          cyc_n = 0;
  logic        as_prev = 1'b1;
  int          n_acc = 0, n_done = 0, n_err = 0, n_strb = 0;
  int          done_cyc = 0, rel_cyc = 0;
  logic [22:0] m_va [8];
  logic [15:0] m_vd [8];
  logic        m_rw [8];
  logic        m_uds [8];
  logic        m_lds [8];
  logic        m_doe [8];

  // Sample 1 time unit after each edge: record accesses, pulses, and drive DTACK.
  always @(posedge MCLK) begin
    #1;
    cyc_n++;
    if (done) begin n_done++; done_cyc = cyc_n; end
    if (error) n_err++;
    if (!AS) n_strb++;
    if (!AS && as_prev) begin
      if (n_acc < 8) begin
        m_va[n_acc] = VA; m_vd[n_acc] = VD_o; m_rw[n_acc] = RW;
        m_uds[n_acc] = UDS; m_lds[n_acc] = LDS; m_doe[n_acc] = data_out_en;
      end
      n_acc++;
    end
    if (AS && !as_prev) rel_cyc = cyc_n;
    as_prev = AS;
    if (!AS) begin
      strb_cnt++;
      if (ack_mode != 0 && strb_cnt == 2) begin
        DTACK = 1'b0;
        VD_i  = rdata;
      end
    end else begin
      strb_cnt = 0;
      DTACK    = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #2;
  endtask

  task automatic clr_mon();
    n_acc = 0; n_done = 0; n_err = 0; n_strb = 0;
  endtask

  task automatic pulse_start(input logic be, input logic bv);
    start = 1'b1; bank_en = be; bank_val = bv;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (done) begin seen = 1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_acc(input string tag, input int n, input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (n_acc >= n) begin seen = 1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit seen;

    // Reset values while SRES_N is held low
    tick(3);
    chk("rst_strobes", {29'd0, AS, UDS, LDS}, 32'h7);
    chk("rst_rw", 32'(RW), 32'd1);
    chk("rst_va", 32'(VA), 32'd0);
    chk("rst_vd_doe", {15'd0, VD_o, data_out_en}, 32'd0);
    chk("rst_status", {24'd0, busy, done, skipped, error, version}, 32'd0);
    SRES_N = 1'b1;
    tick(2);

    // Basic sequence, no bank write, version 3
    ack_mode = 1; rdata = 16'h00A3; clr_mon();
    pulse_start(1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done_seen", 60);
    chk("t1_skipped", 32'(skipped), 32'd0);
    chk("t1_version", 32'(version), 32'd3);
    tick(1);
    chk("t1_busy_fall", {30'd0, busy, done}, 32'd0);
    chk("t1_n_acc", 32'(n_acc), 32'd3);
    chk("t1_va0", 32'(m_va[0]), 32'h508000);
    chk("t1_va1", 32'(m_va[1]), 32'h50A000);
    chk("t1_va2", 32'(m_va[2]), 32'h50A001);
    chk("t1_rw", {29'd0, m_rw[0], m_rw[1], m_rw[2]}, 32'h4);
    chk("t1_doe", {29'd0, m_doe[0], m_doe[1], m_doe[2]}, 32'h3);
    chk("t1_vd1", 32'(m_vd[1]), 32'h5345);
    chk("t1_vd2", 32'(m_vd[2]), 32'h4741);
    chk("t1_ds1", {30'd0, m_uds[1], m_lds[1]}, 32'd0);
    chk("t1_ndone", 32'(n_done), 32'd1);

    // Bank write appended; option inputs change after start and must not matter
    clr_mon();
    pulse_start(1'b1, 1'b1);
    bank_en = 1'b0; bank_val = 1'b0;
    wait_done("t2_done_seen", 80);
    tick(1);
    chk("t2_n_acc", 32'(n_acc), 32'd4);
    chk("t2_va3", 32'(m_va[3]), 32'h50A080);
    chk("t2_ds3", {30'd0, m_uds[3], m_lds[3]}, 32'h2);
    chk("t2_vd3", 32'(m_vd[3]), 32'h0001);
    chk("t2_rw3", {30'd0, m_rw[3], m_doe[3]}, 32'h1);

    // Zero version: skip writes, done one clock after C0 REL
    rdata = 16'h00A0; clr_mon();
    pulse_start(1'b1, 1'b1);
    wait_done("t3_done_seen", 40);
    chk("t3_done_after_rel", 32'(done_cyc - rel_cyc), 32'd1);
    chk("t3_skipped", 32'(skipped), 32'd1);
    chk("t3_version", 32'(version), 32'd0);
    tick(5);
    chk("t3_n_acc", 32'(n_acc), 32'd1);
    chk("t3_skipped_hold", 32'(skipped), 32'd1);

    // Timeout: no acknowledge at all
    ack_mode = 0; clr_mon();
    pulse_start(1'b0, 1'b0);
    chk("t4_skipped_clr", 32'(skipped), 32'd0);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (error) begin seen = 1; break; end
    end
    chk("t4_error_seen", 32'(seen), 32'd1);
    chk("t4_strb_clocks", 32'(n_strb), 32'd255);
    chk("t4_strobes_rel", {29'd0, AS, UDS, LDS}, 32'h7);
    chk("t4_busy_in_err", 32'(busy), 32'd1);
    tick(1);
    chk("t4_busy_fall", {30'd0, busy, error}, 32'd0);
    chk("t4_nerr", 32'(n_err), 32'd1);

    // Reset asserted during C1 strobe, then a fresh run from C0
    ack_mode = 1; rdata = 16'h00A3; clr_mon();
    pulse_start(1'b0, 1'b0);
    wait_acc("t5_reach_c1", 2, 60);
    chk("t5_in_strb", 32'(AS), 32'd0);
    #1 SRES_N = 1'b0;
    #1;
    chk("t5_async_strobes", {29'd0, AS, UDS, LDS}, 32'h7);
    chk("t5_async_busy", {30'd0, busy, data_out_en}, 32'd0);
    tick(2);
    SRES_N = 1'b1;
    tick(3);
    chk("t5_no_resume", 32'(busy), 32'd0);
    clr_mon();
    pulse_start(1'b0, 1'b0);
    wait_done("t5_done_seen", 60);
    tick(1);
    chk("t5_n_acc", 32'(n_acc), 32'd3);
    chk("t5_va0", 32'(m_va[0]), 32'h508000);

    // Start pulsed during C2 is ignored
    clr_mon();
    pulse_start(1'b0, 1'b0);
    wait_acc("t6_reach_c2", 3, 60);
    pulse_start(1'b1, 1'b1);
    wait_done("t6_done_seen", 60);
    tick(20);
    chk("t6_ndone", 32'(n_done), 32'd1);
    chk("t6_n_acc", 32'(n_acc), 32'd3);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmss_unlock_master.md
TMSS_UNLOCK_MASTER -- requirements
Module: tmss_unlock_master

Interface
REQ-001 SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Parameter: TIMEOUT, default 255, maximum MCLK cycles in the strobe state before abort.
REQ-003 MCLK  in  1  system clock; all state changes on the rising edge.
REQ-004 SRES_N  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle request for an unlock sequence; ignored unless idle.
REQ-006 bank_en  in  1  sampled at start; append the bank-register write.
REQ-007 bank_val  in  1  sampled at start; value written to bank bit D0.
REQ-008 DTACK  in  1  active-low bus acknowledge.
REQ-009 VD_i  in  16  read data bus.
REQ-010 VA  out  23  word address.
REQ-011 VD_o  out  16  write data.
REQ-012 data_out_en  out  1  high while VD_o is driven.
REQ-013 AS, UDS, LDS  out  1 each  active-low strobes.
REQ-014 RW  out  1  1=read, 0=write.
REQ-015 busy, done, skipped, error  out  1 each  status; version  out  4  captured hardware version.

Function
REQ-016 The block SHALL be the bus initiator that runs the console security unlock: read version, write "SE", write "GA", optional bank write.
REQ-017 Cycle list SHALL be:
- C0 read, VA=23'h508000, UDS=LDS=0.
- C1 write 16'h5345, VA=23'h50A000, UDS=LDS=0.
- C2 write 16'h4741, VA=23'h50A001, UDS=LDS=0.
- C3 write {15'h0,bank_val}, VA=23'h50A080, LDS=0, UDS=1; only if bank_en.
REQ-018 Bus-cycle FSM states SHALL be IDLE, ADDR, STRB, REL, DONE, ERR.
REQ-019 IDLE->ADDR on start. ADDR lasts exactly 1 clock: VA and RW valid, AS/UDS/LDS high, data_out_en set for writes.
REQ-020 STRB SHALL assert AS plus the required data strobes and hold VA, RW, and VD_o stable; it stays while DTACK=1.
REQ-021 On the first clock with DTACK=0 in STRB, the FSM SHALL go to REL; for C0 it SHALL capture VD_i[3:0] into version on that edge.
REQ-022 REL lasts exactly 1 clock with all strobes high and VA held; it then goes to ADDR of the next cycle, or to DONE.
REQ-023 If C0 returns version==0, C1..C3 SHALL be skipped; REL goes to DONE with skipped=1.
REQ-024 Timeout counter: cleared in ADDR, incremented each STRB clock; on reaching TIMEOUT with DTACK still 1, go to ERR with strobes released that clock.
REQ-025 DONE and ERR SHALL each last 1 clock, pulse done or error respectively, then return to IDLE.
REQ-026 busy=1 in every state except IDLE; skipped and version SHALL hold until the next start.
REQ-027 data_out_en SHALL be 1 from ADDR through REL of write cycles only, and 0 otherwise; VD_o=0 when not driving.
REQ-028 Minimum cycle length SHALL be 3 clocks (ADDR, STRB with immediate DTACK, REL).
REQ-029 start while busy SHALL be ignored; bank_en and bank_val changing mid-sequence SHALL have no effect.

Reset
REQ-030 While SRES_N=0, outputs SHALL be: AS=UDS=LDS=RW=1, VA=0, VD_o=0, data_out_en=0, busy=done=skipped=error=0, version=0, state IDLE.
REQ-031 Reset assertion mid-cycle SHALL release all strobes immediately and asynchronously; the sequence is not resumed after reset.

Structure
REQ-032 A shared package SHALL hold the state enum, the four cycle addresses, the two signature words, and the TIMEOUT default.
REQ-033 One sub-module is natural: tmss_bus_cycle (ADDR/STRB/REL handshake plus timeout), instanced once and sequenced by a top-level cycle-index counter.

Verification
REQ-034 start, bank_en=0, responder with DTACK at 2nd STRB clock, VD_i=16'h00A3 -> C0, C1, C2 in order; version=3; done pulse; skipped=0; no VA=23'h50A080 access.
REQ-035 start, bank_en=1, bank_val=1 -> 4th cycle at VA=23'h50A080 with LDS=0, UDS=1, VD_o=16'h0001, RW=0.
REQ-036 C0 returns VD_i=16'h00A0 -> done one clock after C0 REL, skipped=1, no writes issued.
REQ-037 DTACK held high -> error pulse after exactly TIMEOUT STRB clocks; strobes high; busy falls the following clock.
REQ-038 SRES_N=0 during C1 STRB -> AS/UDS/LDS high without a clock edge; start afterwards restarts from C0.
REQ-039 start pulsed during C2 -> ignored; exactly one done pulse observed.
